// File: rtl/io_bus_responder.sv
//------------------------------------------------------------------------------
// Module      : io_bus_responder
// Description : Responder for the 0xFFxx memory-mapped I/O page. It provides an
//               LED register, a button-strobed switch capture, a transmit FIFO
//               and a free-running cycle counter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module io_bus_responder #(
  parameter int FIFO_DEPTH = 4,
  parameter int LED_W      = 16,
  parameter int SW_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      io_addr,
  input  logic [31:0]      io_dout,
  input  logic             io_we,
  input  logic             io_rd,
  output logic [31:0]      io_din,
  input  logic [SW_W-1:0]  sw,
  input  logic             btn,
  output logic [LED_W-1:0] led,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready
);

  localparam int c_PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_CW = c_PW + 1;

  localparam logic [7:0] c_OFF_LED     = 8'h00;
  localparam logic [7:0] c_OFF_SW_DATA = 8'h04;
  localparam logic [7:0] c_OFF_SW_STAT = 8'h08;
  localparam logic [7:0] c_OFF_TX_DATA = 8'h0C;
  localparam logic [7:0] c_OFF_TX_STAT = 8'h10;
  localparam logic [7:0] c_OFF_CYCLE   = 8'h14;

  logic [LED_W-1:0] r_led;
  logic [SW_W-1:0]  r_sw_meta, r_sw_sync, r_sw_data;
  logic             r_btn_meta, r_btn_sync, r_btn_prev;
  logic             r_sw_valid;
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [c_PW-1:0]  r_rd_ptr, r_wr_ptr;
  logic [c_CW-1:0]  r_count;
  logic             r_ovf;
  logic [31:0]      r_cycle;

  logic        w_sel, w_full, w_empty, w_pop, w_push_req, w_push, w_capture;
  logic        w_sw_rd_clear, w_led_wr, w_ovf_clear;
  logic [7:0]  w_off;
  logic [31:0] w_count32, w_rdata;
  logic        w_unused_ok;

  assign w_sel         = (io_addr[15:8] == 8'hFF);
  assign w_off         = io_addr[7:0];
  assign w_full        = (r_count == c_CW'(FIFO_DEPTH));
  assign w_empty       = (r_count == '0);
  assign w_pop         = !w_empty && tx_ready;
  assign w_push_req    = w_sel && io_we && (w_off == c_OFF_TX_DATA);
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign w_push        = w_push_req && (!w_full || w_pop);
  assign w_led_wr      = w_sel && io_we && (w_off == c_OFF_LED);
  assign w_ovf_clear   = w_sel && io_we && (w_off == c_OFF_TX_STAT) && io_dout[2];
  assign w_sw_rd_clear = w_sel && io_rd && (w_off == c_OFF_SW_DATA);
  assign w_capture     = r_btn_sync && !r_btn_prev;
  assign w_count32     = 32'(r_count);
  assign w_unused_ok   = &{1'b0, io_dout, w_count32[31:4]};

  assign led      = r_led;
  assign tx_valid = !w_empty;
  assign tx_data  = w_empty ? 8'd0 : r_mem[r_rd_ptr];
  assign io_din   = w_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_led      <= '0;
      r_sw_meta  <= '0;
      r_sw_sync  <= '0;
      r_sw_data  <= '0;
      r_btn_meta <= 1'b0;
      r_btn_sync <= 1'b0;
      r_btn_prev <= 1'b0;
      r_sw_valid <= 1'b0;
      r_cycle    <= '0;
    end else begin
      r_sw_meta  <= sw;
      r_sw_sync  <= r_sw_meta;
      r_btn_meta <= btn;
      r_btn_sync <= r_btn_meta;
      r_btn_prev <= r_btn_sync;
      r_cycle    <= r_cycle + 32'd1;
      if (w_led_wr) r_led <= io_dout[LED_W-1:0];
      // Capture has priority over the read-clear.
      if (w_capture) begin
        r_sw_data  <= r_sw_sync;
        r_sw_valid <= 1'b1;
      end else if (w_sw_rd_clear) begin
        r_sw_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PW'(1);
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_push_req && !w_push) r_ovf <= 1'b1;
      else if (w_ovf_clear)      r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= io_dout[7:0];
  end

  always_comb begin
    w_rdata = 32'd0;
    if (w_sel) begin
      case (w_off)
        c_OFF_LED:     w_rdata = 32'(r_led);
        c_OFF_SW_DATA: w_rdata = 32'(r_sw_data);
        c_OFF_SW_STAT: w_rdata = {31'd0, r_sw_valid};
        c_OFF_TX_STAT: w_rdata = {24'd0, w_count32[3:0], 1'b0, r_ovf, w_empty, w_full};
        c_OFF_CYCLE:   w_rdata = r_cycle;
        default:       w_rdata = 32'd0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_io_bus_responder.sv
//------------------------------------------------------------------------------
// Module      : tb_io_bus_responder
// Description : Self-checking bench for io_bus_responder.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_io_bus_responder;

  localparam int c_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] io_addr = '0;
  logic [31:0] io_dout = '0;
  logic        io_we = 1'b0;
  logic        io_rd = 1'b0;
  logic [31:0] io_din;
  logic [15:0] sw = '0;
  logic        btn = 1'b0;
  logic [15:0] led;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0]  m_q [$];
  logic        m_ovf;
  logic [15:0] m_led;
  logic        m_swv;
  logic [15:0] m_swd;

  io_bus_responder #(.FIFO_DEPTH(c_DEPTH), .LED_W(16), .SW_W(16)) dut (
    .clk(clk), .rst(rst), .io_addr(io_addr), .io_dout(io_dout),
    .io_we(io_we), .io_rd(io_rd), .io_din(io_din), .sw(sw), .btn(btn),
    .led(led), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input logic [15:0] a, output logic [31:0] v);
    io_addr = a;
    io_rd   = 1'b1;
    #1;
    v     = io_din;
    io_rd = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    io_addr = a;
    io_dout = d;
    io_we   = 1'b1;
    tick();
    io_we   = 1'b0;
  endtask

  function automatic logic [31:0] exp_read(input logic [15:0] a);
    logic [31:0] v;
    int          n;
    v = 32'd0;
    n = m_q.size();
    if (a[15:8] == 8'hFF) begin
      if (a[7:0] == 8'h00) v = {16'd0, m_led};
      if (a[7:0] == 8'h04) v = {16'd0, m_swd};
      if (a[7:0] == 8'h08) v = {31'd0, m_swv};
      if (a[7:0] == 8'h10) v = (n << 4) | (m_ovf ? 4 : 0) | ((n == 0) ? 2 : 0) | ((n == c_DEPTH) ? 1 : 0);
    end
    return v;
  endfunction

  task automatic test_reset();
    logic [31:0] v;
    #2;
    total++; if (led !== 16'h0) begin bad++; $display("FAIL reset_led: got %h want 0000", led); end
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    peek(16'hFF10, v);
    total++; if (v !== 32'h2) begin bad++; $display("FAIL reset_tx_stat: got %h want 00000002", v); end
    peek(16'hFF08, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL reset_sw_stat: got %h want 0", v); end
    @(posedge clk); #1;
    rst = 1'b0;
    peek(16'hFF14, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL reset_cycle0: got %h want 0", v); end
    tick();
    peek(16'hFF14, v);
    total++; if (v !== 32'h1) begin bad++; $display("FAIL reset_cycle1: got %h want 1", v); end
  endtask

  task automatic test_led();
    logic [31:0] v;
    wr(16'hFF00, 32'h0001A5C3);
    total++; if (led !== 16'hA5C3) begin bad++; $display("FAIL led_write: got %h want a5c3", led); end
    peek(16'hFF00, v);
    total++; if (v !== 32'h0000A5C3) begin bad++; $display("FAIL led_read: got %h want 0000a5c3", v); end
    wr(16'h0F00, 32'h0000FFFF);
    total++; if (led !== 16'hA5C3) begin bad++; $display("FAIL led_offpage: got %h want a5c3", led); end
    wr(16'hFF02, 32'h00001111);
    total++; if (led !== 16'hA5C3) begin bad++; $display("FAIL led_unmapped_wr: got %h want a5c3", led); end
  endtask

  task automatic test_switch();
    logic [31:0] v;
    sw  = 16'h1234;
    btn = 1'b1;
    tick();
    peek(16'hFF08, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL sw_lat1: got %h want 0", v); end
    tick();
    peek(16'hFF08, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL sw_lat2: got %h want 0", v); end
    tick();
    peek(16'hFF08, v);
    total++; if (v !== 32'h1) begin bad++; $display("FAIL sw_lat3: got %h want 1", v); end
    btn = 1'b0;
    io_addr = 16'hFF04; io_rd = 1'b1; #1;
    total++; if (io_din !== 32'h1234) begin bad++; $display("FAIL sw_data: got %h want 1234", io_din); end
    tick();
    io_rd = 1'b0;
    peek(16'hFF08, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL sw_rdclear: got %h want 0", v); end
    tick(); tick(); tick();
    sw  = 16'h5678;
    btn = 1'b1;
    tick(); tick();
    io_addr = 16'hFF04; io_rd = 1'b1; #1;
    total++; if (io_din !== 32'h1234) begin bad++; $display("FAIL sw_pre_edge: got %h want 1234", io_din); end
    tick();
    io_rd = 1'b0;
    btn   = 1'b0;
    peek(16'hFF08, v);
    total++; if (v !== 32'h1) begin bad++; $display("FAIL sw_set_wins: got %h want 1", v); end
    peek(16'hFF04, v);
    total++; if (v !== 32'h5678) begin bad++; $display("FAIL sw_new_data: got %h want 5678", v); end
  endtask

  task automatic test_unmapped();
    logic [31:0] v;
    peek(16'hFF20, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL unmapped_rd: got %h want 0", v); end
    io_addr = 16'h1004; io_rd = 1'b1; #1;
    total++; if (io_din !== 32'h0) begin bad++; $display("FAIL offpage_rd: got %h want 0", io_din); end
    tick();
    io_rd = 1'b0;
    peek(16'hFF08, v);
    total++; if (v !== 32'h1) begin bad++; $display("FAIL offpage_noclear: got %h want 1", v); end
    peek(16'hFF0C, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL txdata_rd: got %h want 0", v); end
  endtask

  task automatic test_fifo_order();
    logic [31:0] v;
    logic [7:0]  exp_b [4];
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) wr(16'hFF0C, {24'd0, exp_b[i]});
    peek(16'hFF10, v);
    total++; if (v !== 32'h41) begin bad++; $display("FAIL fifo_full_stat: got %h want 41", v); end
    wr(16'hFF0C, 32'h55);
    peek(16'hFF10, v);
    total++; if (v !== 32'h45) begin bad++; $display("FAIL fifo_ovf_stat: got %h want 45", v); end
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (tx_valid !== 1'b1 || tx_data !== exp_b[i]) begin
        bad++; $display("FAIL fifo_drain%0d: got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, exp_b[i]);
      end
      tick();
    end
    tx_ready = 1'b0;
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL fifo_empty_valid: got %b want 0", tx_valid); end
    peek(16'hFF10, v);
    total++; if (v !== 32'h06) begin bad++; $display("FAIL fifo_empty_stat: got %h want 06", v); end
    wr(16'hFF10, 32'h4);
    peek(16'hFF10, v);
    total++; if (v !== 32'h02) begin bad++; $display("FAIL ovf_clear: got %h want 02", v); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] v;
    logic [7:0]  exp_b [4];
    exp_b = '{8'hA2, 8'hA3, 8'hA4, 8'h99};
    tx_ready = 1'b0;
    wr(16'hFF0C, 32'hA1);
    for (int i = 0; i < 3; i++) wr(16'hFF0C, {24'd0, exp_b[i]});
    tx_ready = 1'b1;
    total++; if (tx_data !== 8'hA1) begin bad++; $display("FAIL fpp_head: got %h want a1", tx_data); end
    wr(16'hFF0C, 32'h99);
    tx_ready = 1'b0;
    peek(16'hFF10, v);
    total++; if (v !== 32'h41) begin bad++; $display("FAIL fpp_stat: got %h want 41", v); end
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (tx_valid !== 1'b1 || tx_data !== exp_b[i]) begin
        bad++; $display("FAIL fpp_drain%0d: got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, exp_b[i]);
      end
      tick();
    end
    tx_ready = 1'b0;
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL fpp_empty: got %b want 0", tx_valid); end
  endtask

  task automatic test_cycle();
    logic [31:0] c0, c1;
    peek(16'hFF14, c0);
    for (int i = 0; i < 5; i++) tick();
    peek(16'hFF14, c1);
    total++; if (c1 - c0 !== 32'd5) begin bad++; $display("FAIL cycle_step: got %0d want 5", c1 - c0); end
    force dut.r_cycle = 32'hFFFF_FFFF;
    peek(16'hFF14, c0);
    total++; if (c0 !== 32'hFFFF_FFFF) begin bad++; $display("FAIL cycle_forced: got %h want ffffffff", c0); end
    release dut.r_cycle;
    tick();
    peek(16'hFF14, c1);
    total++; if (c1 !== 32'h0) begin bad++; $display("FAIL cycle_wrap: got %h want 0", c1); end
  endtask

  task automatic test_async_reset();
    logic [31:0] v;
    tx_ready = 1'b0;
    wr(16'hFF00, 32'h0000BEEF);
    wr(16'hFF0C, 32'h01);
    wr(16'hFF0C, 32'h02);
    #2;
    rst = 1'b1;
    #1;
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL arst_tx_valid: got %b want 0", tx_valid); end
    total++; if (led !== 16'h0) begin bad++; $display("FAIL arst_led: got %h want 0", led); end
    peek(16'hFF10, v);
    total++; if (v !== 32'h2) begin bad++; $display("FAIL arst_tx_stat: got %h want 2", v); end
    rst = 1'b0;
    tick();
    peek(16'hFF14, v);
    total++; if (v !== 32'h1) begin bad++; $display("FAIL arst_cycle: got %h want 1", v); end
    peek(16'hFF04, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL arst_sw_data: got %h want 0", v); end
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [31:0] d, e;
    logic        we, rd, rdy, sel, pop, push_req, accept;
    int          op;
    logic [7:0]  offs [7];
    offs  = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h20, 8'h01};
    m_q   = {};
    m_ovf = 1'b0;
    m_led = 16'h0;
    m_swv = 1'b0;
    m_swd = 16'h0;
    for (int n = 0; n < 400; n++) begin
      op  = $urandom_range(0, 6);
      d   = $urandom;
      we  = 1'b0;
      rd  = 1'b0;
      rdy = ($urandom_range(0, 2) == 0);
      case (op)
        0:       begin a = 16'hFF00; we = 1'b1; end
        1, 2:    begin a = 16'hFF0C; we = 1'b1; end
        3:       begin a = 16'hFF10; we = 1'b1; d[2] = ($urandom_range(0, 3) == 0); end
        4, 5:    begin a = {8'hFF, offs[$urandom_range(0, 6)]}; rd = 1'b1; end
        default: begin a = {8'h12, offs[$urandom_range(0, 6)]}; we = 1'b1; rd = 1'b1; end
      endcase
      io_addr = a; io_dout = d; io_we = we; io_rd = rd; tx_ready = rdy;
      #1;
      e = exp_read(a);
      if (rd) begin
        total++; if (io_din !== e) begin bad++; $display("FAIL rnd_read[%0d] @%h: got %h want %h", n, a, io_din, e); end
      end
      total++;
      if (tx_valid !== (m_q.size() != 0) || (m_q.size() != 0 && tx_data !== m_q[0])) begin
        bad++; $display("FAIL rnd_tx[%0d]: got v=%b d=%h want n=%0d", n, tx_valid, tx_data, m_q.size());
      end
      sel      = (a[15:8] == 8'hFF);
      pop      = (m_q.size() != 0) && rdy;
      push_req = we && sel && (a[7:0] == 8'h0C);
      accept   = push_req && ((m_q.size() < c_DEPTH) || pop);
      tick();
      if (we && sel && a[7:0] == 8'h00) m_led = d[15:0];
      if (rd && sel && a[7:0] == 8'h04) m_swv = 1'b0;
      if (pop) void'(m_q.pop_front());
      if (accept) m_q.push_back(d[7:0]);
      if (push_req && !accept) m_ovf = 1'b1;
      else if (we && sel && a[7:0] == 8'h10 && d[2]) m_ovf = 1'b0;
      total++; if (led !== m_led) begin bad++; $display("FAIL rnd_led[%0d]: got %h want %h", n, led, m_led); end
    end
    io_we = 1'b0; io_rd = 1'b0; tx_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_led();
    test_switch();
    test_unmapped();
    test_fifo_order();
    test_full_push_pop();
    test_cycle();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/io_bus_responder.md
# io_bus_responder

Peripheral-side responder for the CPU's memory-mapped I/O bus: it answers every access the data-memory unit forwards to the 0xFFxx address page. It holds an LED output register and a button-strobed switch capture register with a valid flag. It also holds a 4-entry transmit FIFO drained by a valid/ready consumer and a free-running cycle counter. It sits beside the data memory and drives the I/O read data that the data-memory unit selects for addresses 0xFF00–0xFFFF.

## Interface
- FIFO_DEPTH, 4, transmit FIFO entries; power of two, ≥2.
- LED_W, 16, LED register width.
- SW_W, 16, switch input width.
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- io_addr  in  16  I/O byte address from the CPU side.
- io_dout  in  32  write data from the CPU side.
- io_we  in  1  write strobe, qualified by the page decode.
- io_rd  in  1  read strobe, qualified by the page decode.
- io_din  out  32  read data to the CPU side.
- sw  in  SW_W  asynchronous switch inputs.
- btn  in  1  asynchronous capture button.
- led  out  LED_W  LED register.
- tx_data  out  8  FIFO head byte.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  consumer accepts head this cycle.

## Operation
- Page hit: sel = (io_addr[15:8] == 8'hFF). When sel=0, io_we and io_rd have no effect and io_din = 0.
- Offsets are decoded on io_addr[7:0]. An unmapped offset reads 0 and ignores writes.
- 0x00 LED (R/W): a write loads io_dout[LED_W-1:0] into led. A read returns led, zero-extended.
- 0x04 SW_DATA (R): returns the captured switch value, zero-extended. A read with io_rd=1 clears SW_VALID.
- 0x08 SW_STAT (R): bit0 = SW_VALID; all other bits are 0.
- 0x0C TX_DATA (W): a write pushes io_dout[7:0] into the FIFO. A read returns 0.
- 0x10 TX_STAT (R/W):
  - Read fields: bit0 full, bit1 empty, bit2 OVF (sticky), bits[7:4] count, other bits 0.
  - A write with io_dout[2]=1 clears OVF.
- 0x14 CYCLE (R): 32-bit counter that increments every cycle and wraps 0xFFFFFFFF→0.
- Button capture:
  - btn and sw each pass through a 2-flop synchronizer.
  - A rising edge of synchronized btn loads SW_DATA from synchronized sw and sets SW_VALID.
  - Capture overwrites any unread value.
  - If a capture and a clearing read land in the same cycle, the set wins: SW_VALID=1 with the new data.
- FIFO:
  - tx_valid = !empty; tx_data = head entry.
  - Pop when tx_valid && tx_ready.
  - A push is accepted when count < FIFO_DEPTH, or when the FIFO is full and a pop occurs in the same cycle; in that case count is unchanged and the order is preserved.
  - A push into a full FIFO with no pop is dropped, and OVF is set.
  - A simultaneous push and pop on an empty FIFO: push only, because tx_valid=0.
  - Pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH.
- Same-cycle io_we and io_rd: the write commits at the clock edge, and io_din returns the pre-edge value.
- OVF set and clear in the same cycle: set wins.

## Timing
- io_din is combinational from io_addr and current register state, valid in the same cycle as io_rd. This matches the data-memory unit's same-cycle read mux.
- All register updates, the read-clear, and FIFO push/pop take effect at the rising edge that samples the strobe.
- A pushed byte appears on tx_valid/tx_data the cycle after the push edge.
- btn-to-SW_VALID latency: 3 rising edges after btn rises (2 synchronizer stages plus the edge-detect register).
- Reset (asynchronous, takes effect immediately):
  - led=0, SW_DATA=0, SW_VALID=0, synchronizers=0.
  - FIFO empty: count=0, pointers=0, tx_valid=0, tx_data=0.
  - OVF=0, CYCLE=0.
  - io_din reflects the reset state, e.g. 0x10 reads 0x2.
- Reset mid-operation discards FIFO contents and any pending capture. The first post-reset edge starts CYCLE counting from 0 (reads 1 after the first edge).

## Test plan
- LED: write 0xFF00 data 0x0001A5C3 -> led=16'hA5C3 next cycle, read 0xFF00 returns 0x0000A5C3. A write to 0x0F00 leaves led unchanged.
- Switch capture: sw=16'h1234, pulse btn -> SW_STAT reads 1 after 3 edges, SW_DATA reads 0x1234. That read clears SW_STAT to 0. Capture on the same edge as a read -> SW_VALID stays 1.
- FIFO ordering: tx_ready=0, write 0xFF0C with 0x11, 0x22, 0x33, 0x44 -> TX_STAT=0x41. A fifth write 0x55 -> dropped, TX_STAT=0x45. tx_ready=1 -> bytes 0x11, 0x22, 0x33, 0x44 on consecutive cycles, then TX_STAT=0x06. Write 0x4 to 0xFF10 -> TX_STAT=0x02.
- Full push+pop: FIFO full, tx_ready=1 and a write of 0x99 in the same cycle -> OVF stays 0, count stays 4, and 0x99 drains last.
- Counter wrap and reset: force CYCLE to 0xFFFFFFFF -> reads 0 next cycle. Assert rst asynchronously mid-burst -> tx_valid=0, led=0, and 0xFF10 reads 0x2 immediately.
- Unmapped access: read 0xFF20 -> 0. A read of 0x1004 with io_rd=1 -> io_din=0 and SW_VALID unaffected.
